// File: rtl/vga_timing_pkg.sv
// Raster geometry, board width and page bit indices shared by the VGA timing slice.
package vga_timing_pkg;

   localparam int unsigned H_SYNC = 96;
   localparam int unsigned H_BP   = 48;
   localparam int unsigned H_ACT  = 640;
   localparam int unsigned H_FP   = 16;

   localparam int unsigned V_SYNC = 2;
   localparam int unsigned V_BP   = 33;
   localparam int unsigned V_ACT  = 480;
   localparam int unsigned V_FP   = 10;

   localparam int unsigned H_ACT_START = H_SYNC + H_BP;          // 144
   localparam int unsigned H_FP_START  = H_ACT_START + H_ACT;    // 784
   localparam int unsigned V_ACT_START = V_SYNC + V_BP;          // 35
   localparam int unsigned V_FP_START  = V_ACT_START + V_ACT;    // 515

   localparam int unsigned BROAD_W = 1486;
   localparam int unsigned CNT_W   = 10;

   typedef enum int unsigned {
      PG_HOME     = 0,
      PG_SEARCH   = 1,
      PG_WARN_RUN = 2,
      PG_WARN     = 3,
      PG_START    = 4
   } page_bit_e;

   localparam logic [4:0] PAGE_RST = 5'(1 << PG_HOME);

   function automatic logic [CNT_W-1:0] cnt10(input int unsigned x);
      return CNT_W'(x);
   endfunction

endpackage

// File: rtl/vga_timing_sync_if.sv
// Game-side snapshot handshake and shadowed renderer data between game logic and the timing block.
interface vga_timing_sync_if;
   import vga_timing_pkg::*;

   logic [4:0]         state_in;
   logic [BROAD_W-1:0] broad_in;
   logic signed [15:0] site_X_in;
   logic signed [15:0] site_Y_in;
   logic               upd_valid;
   logic               upd_ready;
   logic               frame_tick;
   logic [4:0]         state;
   logic [BROAD_W-1:0] broad;
   logic signed [15:0] site_X;
   logic signed [15:0] site_Y;

   modport master (
      output state_in, broad_in, site_X_in, site_Y_in, upd_valid,
      input  upd_ready, frame_tick, state, broad, site_X, site_Y
   );

   modport slave (
      input  state_in, broad_in, site_X_in, site_Y_in, upd_valid,
      output upd_ready, frame_tick, state, broad, site_X, site_Y
   );

endinterface

// File: rtl/vga_shadow_regs.sv
// Front-porch capture handshake and shadow bundle; VGA_SHADOW_EN selects registered
// shadows, otherwise the bundle is a combinational pass-through with upd_ready tied high.
module vga_shadow_regs
   import vga_timing_pkg::*;
(
   input  logic R_clk_25M,
   input  logic I_rst_n,
`ifdef VGA_SHADOW_EN
   input  logic i_win_nxt,
`endif
   input  logic i_tick_nxt,
   vga_timing_sync_if.slave bus
);

`ifdef VGA_SHADOW_EN
   logic r_win_used;
   logic w_accept;
   logic w_used_nxt;

   assign w_accept   = bus.upd_valid && bus.upd_ready;
   assign w_used_nxt = r_win_used || w_accept;

   always_ff @(posedge R_clk_25M or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_win_used     <= 1'b0;
         bus.upd_ready  <= 1'b0;
         bus.frame_tick <= 1'b0;
         bus.state      <= PAGE_RST;
         bus.broad      <= '0;
         bus.site_X     <= '0;
         bus.site_Y     <= '0;
      end else begin
         bus.frame_tick <= i_tick_nxt;
         // Flag only survives inside the window, so leaving it re-arms the next frame.
         r_win_used     <= i_win_nxt && w_used_nxt;
         bus.upd_ready  <= i_win_nxt && !w_used_nxt;
         if (w_accept) begin
            bus.state  <= bus.state_in;
            bus.broad  <= bus.broad_in;
            bus.site_X <= bus.site_X_in;
            bus.site_Y <= bus.site_Y_in;
         end
      end
   end
`else
   logic w_unused_valid;

   assign w_unused_valid = bus.upd_valid;
   assign bus.upd_ready  = 1'b1;
   assign bus.state      = bus.state_in;
   assign bus.broad      = bus.broad_in;
   assign bus.site_X     = bus.site_X_in;
   assign bus.site_Y     = bus.site_Y_in;

   always_ff @(posedge R_clk_25M or negedge I_rst_n) begin
      if (!I_rst_n) begin
         bus.frame_tick <= 1'b0;
      end else begin
         bus.frame_tick <= i_tick_nxt;
      end
   end
`endif

endmodule

// File: rtl/vga_timing_sync.sv
// 640x480@60 raster counters with sync/active decode and a frame-coherent shadow of game state.
// Build option VGA_SHADOW_EN enables the front-porch shadow registers in vga_shadow_regs.
module vga_timing_sync
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_TOTAL  = H_SYNC + H_BP + H_ACT + H_FP,
   parameter int unsigned V_TOTAL  = V_SYNC + V_BP + V_ACT + V_FP,
   parameter int unsigned H_SYNC_W = H_SYNC,
   parameter int unsigned H_BP_W   = H_BP,
   parameter int unsigned H_ACT_W  = H_ACT,
   parameter int unsigned V_SYNC_W = V_SYNC,
   parameter int unsigned V_BP_W   = V_BP,
   parameter int unsigned V_ACT_W  = V_ACT
) (
   input  logic             R_clk_25M,
   input  logic             I_rst_n,
   vga_timing_sync_if.slave bus,
   output logic [9:0]       R_h_cnt,
   output logic [9:0]       R_v_cnt,
   output logic             W_active_flag,
   output logic             O_hs,
   output logic             O_vs
);

   localparam logic [9:0] C_H_LAST    = cnt10(H_TOTAL - 1);
   localparam logic [9:0] C_V_LAST    = cnt10(V_TOTAL - 1);
   localparam logic [9:0] C_HS_END    = cnt10(H_SYNC_W);
   localparam logic [9:0] C_HA_START  = cnt10(H_SYNC_W + H_BP_W);
   localparam logic [9:0] C_HA_END    = cnt10(H_SYNC_W + H_BP_W + H_ACT_W);
   localparam logic [9:0] C_VS_END    = cnt10(V_SYNC_W);
   localparam logic [9:0] C_VA_START  = cnt10(V_SYNC_W + V_BP_W);
   localparam logic [9:0] C_VFP_START = cnt10(V_SYNC_W + V_BP_W + V_ACT_W);

   logic [9:0] w_h_nxt;
   logic [9:0] w_v_nxt;
   logic       w_hs_nxt;
   logic       w_vs_nxt;
   logic       w_act_nxt;
   logic       w_tick_nxt;

   always_comb begin
      w_h_nxt = R_h_cnt + 10'd1;
      w_v_nxt = R_v_cnt;
      if (R_h_cnt == C_H_LAST) begin
         w_h_nxt = '0;
         w_v_nxt = (R_v_cnt == C_V_LAST) ? '0 : R_v_cnt + 10'd1;
      end
   end

   // Flags decode the next counts so they register alongside the counters.
   assign w_hs_nxt   = (w_h_nxt >= C_HS_END);
   assign w_vs_nxt   = (w_v_nxt >= C_VS_END);
   assign w_act_nxt  = (w_h_nxt >= C_HA_START) && (w_h_nxt < C_HA_END) &&
                       (w_v_nxt >= C_VA_START) && (w_v_nxt < C_VFP_START);
   assign w_tick_nxt = (w_h_nxt == '0) && (w_v_nxt == C_VFP_START);

   always_ff @(posedge R_clk_25M or negedge I_rst_n) begin
      if (!I_rst_n) begin
         R_h_cnt       <= '0;
         R_v_cnt       <= '0;
         O_hs          <= 1'b0;
         O_vs          <= 1'b0;
         W_active_flag <= 1'b0;
      end else begin
         R_h_cnt       <= w_h_nxt;
         R_v_cnt       <= w_v_nxt;
         O_hs          <= w_hs_nxt;
         O_vs          <= w_vs_nxt;
         W_active_flag <= w_act_nxt;
      end
   end

`ifdef VGA_SHADOW_EN
   logic w_win_nxt;

   assign w_win_nxt = (w_v_nxt >= C_VFP_START);
`endif

   vga_shadow_regs u_shadow (
      .R_clk_25M  (R_clk_25M),
      .I_rst_n    (I_rst_n),
`ifdef VGA_SHADOW_EN
      .i_win_nxt  (w_win_nxt),
`endif
      .i_tick_nxt (w_tick_nxt),
      .bus        (bus)
   );

endmodule
